// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port 32-bit data memory that answers CPU requests with a fixed,
//   parameterised number of wait states. The request is latched on acceptance,
//   so the CPU may change its bus while the access is in flight.
//
// Parameters
//   WAIT_STATES  extra wait cycles before each response (0..15)
//   ADDR_BITS    word-address width; storage is 2**ADDR_BITS x 32 bits
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   mem_addr     byte address; word index = mem_addr[ADDR_BITS+1:2]
//   mem_wdata    write data
//   mem_we/re    write / read request (both high = error)
//   mem_rdata    read data, valid with mem_ready after a good read
//   mem_ready    one-cycle response strobe
//   mem_err      error flag, only ever high together with mem_ready
//   busy         high from acceptance through the mem_ready cycle
module data_mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, re_q;
  logic        accept, finish, req_err;
  logic [ADDR_BITS-1:0] word_idx;

  // Storage has no reset: contents survive rst_n and start as X.
  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  assign accept   = (state == IDLE) && (mem_we || mem_re);
  // The WAIT->RESP edge is where the access actually takes effect.
  assign finish   = (state == WAIT) && (cnt == 4'd0);
  assign word_idx = addr_q[ADDR_BITS+1:2];
  // Misaligned, out of range (any bit above the word index), or both strobes.
  assign req_err  = (addr_q[1:0] != 2'b00) || (|addr_q[31:ADDR_BITS+2]) ||
                    (we_q && re_q);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (mem_we || mem_re) begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(WAIT_STATES);
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= finish;
      mem_err   <= finish && req_err;
      // rdata only moves on a completed read or an error; writes leave it.
      if (finish) begin
        if (req_err)   mem_rdata <= 32'h0;
        else if (re_q) mem_rdata <= mem[word_idx];
      end
    end
  end

  // Request latch: only loaded in IDLE, so bus changes mid-access are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      we_q    <= mem_we;
      re_q    <= mem_re;
    end
  end

  // A reset during WAIT drops state to IDLE, so finish never fires and the
  // aborted write is lost.
  always_ff @(posedge clk) begin
    if (finish && we_q && !req_err) mem[word_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int AB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0;
  logic        sel = 1'b1;  // 1: WAIT_STATES=2 instance, 0: WAIT_STATES=0

  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2, err0, err2, busy0, busy2;
  logic        we0, re0, we2, re2;

  assign we0 = we & ~sel;
  assign re0 = re & ~sel;
  assign we2 = we & sel;
  assign re2 = re & sel;

  data_mem_responder #(.WAIT_STATES(0), .ADDR_BITS(AB)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata),
    .mem_we(we0), .mem_re(re0), .mem_rdata(rdata0), .mem_ready(rdy0),
    .mem_err(err0), .busy(busy0));

  data_mem_responder #(.WAIT_STATES(2), .ADDR_BITS(AB)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata),
    .mem_we(we2), .mem_re(re2), .mem_rdata(rdata2), .mem_ready(rdy2),
    .mem_err(err2), .busy(busy2));

  always #5 clk = ~clk;

  logic [31:0] rdata_s;
  logic        rdy_s, err_s, busy_s;
  assign rdata_s = sel ? rdata2 : rdata0;
  assign rdy_s   = sel ? rdy2   : rdy0;
  assign err_s   = sel ? err2   : err0;
  assign busy_s  = sel ? busy2  : busy0;

  int errs = 0, checks = 0;

  // Reference memory: one word per (instance, word index); absent = never written.
  bit [31:0] mdl [int];

  typedef struct {
    logic [31:0] a, d;
    logic        w, r;
    logic        xe;   // expected error
    logic        cr;   // compare read data
    logic [31:0] xr;   // expected read data
  } vec_t;
  vec_t tv2[$], tv0[$];

  function automatic vec_t mk(logic [31:0] a, d, logic w, r, xe, cr, logic [31:0] xr);
    vec_t v;
    v.a = a; v.d = d; v.w = w; v.r = r; v.xe = xe; v.cr = cr; v.xr = xr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction, entered and left at a negedge with the DUT idle.
  task automatic txn(input logic [31:0] a, d, input logic w, r,
                     output logic [31:0] rd, output logic e, output int lat);
    addr = a; wdata = d; we = w; re = r;
    @(posedge clk);              // acceptance edge k
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    addr = $urandom; wdata = $urandom;  // latched request must be unaffected
    chk("busy_after_accept", 32'(busy_s), 32'd1);
    lat = 0;
    while (!rdy_s && lat < 40) begin
      chk("err_low_without_ready", 32'(err_s), 32'd0);
      @(posedge clk); lat++;
      @(negedge clk);
    end
    rd = rdata_s; e = err_s;
    chk("busy_in_resp", 32'(busy_s), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("ready_one_cycle", 32'(rdy_s), 32'd0);
    chk("busy_back_idle", 32'(busy_s), 32'd0);
  endtask

  // Transaction checked against the reference model; model updated on good writes.
  task automatic do_req(input logic [31:0] a, d, input logic w, r,
                        output logic [31:0] rd, output logic e);
    int lat, ws, key;
    bit bad;
    ws  = sel ? 2 : 0;
    key = (sel ? 65536 : 0) + int'(a[AB+1:2]);
    bad = (a % 4 != 0) || (a >= (32'd4 << AB)) || (w && r);
    txn(a, d, w, r, rd, e, lat);
    chk("latency", lat, 1 + ws);
    chk("model_err", 32'(e), 32'(bad));
    if (bad) chk("model_err_rdata", rd, 32'h0);
    else if (r && mdl.exists(key)) chk("model_rdata", rd, mdl[key]);
    if (w && !bad) mdl[key] = d;
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic e, w, r;
    int edges[$];
    int n;

    tv2.push_back(mk(32'h10,  32'hDEADBEEF, 1, 0, 0, 0, 0));
    tv2.push_back(mk(32'h10,  32'h0,        0, 1, 0, 1, 32'hDEADBEEF));
    tv2.push_back(mk(32'h0,   32'h0000AAAA, 1, 0, 0, 0, 0));
    tv2.push_back(mk(32'h4,   32'h0000BBBB, 1, 0, 0, 0, 0));
    tv2.push_back(mk(32'h6,   32'h0,        0, 1, 1, 1, 32'h0));
    tv2.push_back(mk(32'h400, 32'h0,        0, 1, 1, 1, 32'h0));
    tv2.push_back(mk(32'h4,   32'h0,        0, 1, 0, 1, 32'h0000BBBB));
    tv2.push_back(mk(32'h0,   32'h0,        0, 1, 0, 1, 32'h0000AAAA));
    tv2.push_back(mk(32'h8,   32'h12345678, 1, 0, 0, 0, 0));
    tv2.push_back(mk(32'h8,   32'hFFFFFFFF, 1, 1, 1, 1, 32'h0));
    tv2.push_back(mk(32'h8,   32'h0,        0, 1, 0, 1, 32'h12345678));
    tv2.push_back(mk(32'h400, 32'h55555555, 1, 0, 1, 0, 0));
    tv2.push_back(mk(32'h80000000, 32'h66666666, 1, 0, 1, 0, 0));
    tv2.push_back(mk(32'h2,   32'h77777777, 1, 0, 1, 0, 0));
    tv2.push_back(mk(32'h0,   32'h0,        0, 1, 0, 1, 32'h0000AAAA));
    tv0.push_back(mk(32'h0,   32'h0000000A, 1, 0, 0, 0, 0));
    tv0.push_back(mk(32'h4,   32'h00000014, 1, 0, 0, 0, 0));
    tv0.push_back(mk(32'h0,   32'h0,        0, 1, 0, 1, 32'h0000000A));
    tv0.push_back(mk(32'h4,   32'h0,        0, 1, 0, 1, 32'h00000014));

    // Reset state, both instances.
    #1;
    chk("rst_ready", {30'd0, rdy0, rdy2}, 32'd0);
    chk("rst_err",   {30'd0, err0, err2}, 32'd0);
    chk("rst_busy",  {30'd0, busy0, busy2}, 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed tables.
    sel = 1'b1;
    foreach (tv2[i]) begin
      do_req(tv2[i].a, tv2[i].d, tv2[i].w, tv2[i].r, rd, e);
      chk($sformatf("tv2[%0d].err", i), 32'(e), 32'(tv2[i].xe));
      if (tv2[i].cr) chk($sformatf("tv2[%0d].rdata", i), rd, tv2[i].xr);
    end
    sel = 1'b0;
    @(negedge clk);
    foreach (tv0[i]) begin
      do_req(tv0[i].a, tv0[i].d, tv0[i].w, tv0[i].r, rd, e);
      chk($sformatf("tv0[%0d].err", i), 32'(e), 32'(tv0[i].xe));
      if (tv0[i].cr) chk($sformatf("tv0[%0d].rdata", i), rd, tv0[i].xr);
    end

    // Held request: each instance must re-accept only from IDLE, giving
    // ready strobes WAIT_STATES+3 edges apart.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      edges.delete();
      addr = 32'h0; wdata = 32'h0; re = 1'b1; we = 1'b0;
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); @(negedge clk);
        if (rdy_s) begin
          edges.push_back(c);
          chk("held_rdata", rdata_s, s ? 32'h0000AAAA : 32'h0000000A);
        end
      end
      re = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("held_count_min", 32'(edges.size() >= 3), 32'd1);
      for (int k = 1; k < edges.size(); k++)
        chk("held_gap", edges[k] - edges[k-1], s ? 5 : 3);
    end

    // Reset during WAIT aborts a write.
    sel = 1'b1;
    @(negedge clk);
    do_req(32'h20, 32'h11111111, 1, 0, rd, e);
    do_req(32'h10, 32'h0, 0, 1, rd, e);   // leaves rdata nonzero
    addr = 32'h20; wdata = 32'hCAFEF00D; we = 1'b1;
    @(posedge clk); @(negedge clk);
    we = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy_s), 32'd0);
    chk("midrst_busy",  32'(busy_s), 32'd0);
    chk("midrst_err",   32'(err_s), 32'd0);
    chk("midrst_rdata", rdata_s, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdy_s) n++;
    end
    chk("midrst_no_ready", n, 0);
    do_req(32'h20, 32'h0, 0, 1, rd, e);
    chk("midrst_old_data", rd, 32'h11111111);

    // Randomised traffic against the model, both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int t = 0; t < 60; t++) begin
        a = 32'($urandom_range(0, 15)) * 4;
        case ($urandom_range(0, 9))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = a | (32'd1 << $urandom_range(AB + 2, 31));
          default: ;
        endcase
        d = $urandom;
        case ($urandom_range(0, 4))
          0:       begin w = 1; r = 1; end
          1, 2:    begin w = 1; r = 0; end
          default: begin w = 0; r = 1; end
        endcase
        do_req(a, d, w, r, rd, e);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
